// File: rtl/w_wr_arbiter.sv
// w_wr_arbiter: round-robin arbiter that shares the single write port of an async FIFO
// among NUM_REQ requesters in the write clock domain. It performs no clock-domain crossing.
//
// Ports:
//   w_clk        write-domain clock
//   w_rst        synchronous active-high reset
//   w_req_valid  per-requester word-present flags
//   w_req_data   requester i data in [i*DATA_SIZE +: DATA_SIZE]
//   w_req_last   per-requester end-of-packet flags (used only with packet lock)
//   w_req_ready  per-requester accept strobes
//   w_full       registered full flag from the FIFO write-pointer block
//   w_inc        write strobe to the FIFO pointer block and memory
//   w_data       write data to the FIFO memory
//   w_grant_id   current grant holder (meaningful while w_busy)
//   w_busy       a grant is held
//   w_stall      grant holder is valid but the FIFO is full
//
// Build option: define W_WR_ARB_PKT_LOCK_EN to hold the grant until the word marked
// w_req_last is accepted, so packets are never interleaved in the FIFO.
module w_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ID_SIZE   = 2
) (
    input  logic                           w_clk,
    input  logic                           w_rst,
    input  logic [NUM_REQ-1:0]             w_req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   w_req_data,
    input  logic [NUM_REQ-1:0]             w_req_last,
    output logic [NUM_REQ-1:0]             w_req_ready,
    input  logic                           w_full,
    output logic                           w_inc,
    output logic [DATA_SIZE-1:0]           w_data,
    output logic [ID_SIZE-1:0]             w_grant_id,
    output logic                           w_busy,
    output logic                           w_stall
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e             r_state, w_state_nxt;
    logic [ID_SIZE-1:0] r_g, w_g_nxt;
    logic [ID_SIZE-1:0] r_p, w_p_nxt;
    logic               w_holder_valid;
    logic               w_xfer;
    logic               w_rearb;

`ifdef W_WR_ARB_PKT_LOCK_EN
    // Set while a packet is partially written; keeps the grant even if valid drops.
    logic r_lock, w_lock_nxt;
`else
    logic w_unused_last;
    assign w_unused_last = ^w_req_last;
`endif

    // First valid index after 'start', wrapping; 'start' itself is checked last.
    function automatic logic [ID_SIZE-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [ID_SIZE-1:0] start);
        logic [ID_SIZE-1:0] pick;
        logic               found;
        int unsigned        idx;
        pick  = start;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(start) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                pick  = ID_SIZE'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_holder_valid = w_req_valid[r_g];
    // Gated by reset so nothing is written in the reset cycle.
    assign w_xfer = (r_state == StGrant) & w_holder_valid & ~w_full & ~w_rst;

    always_comb begin
        w_req_ready = '0;
        if (r_state == StGrant && !w_rst) begin
            w_req_ready[r_g] = ~w_full;
        end
        w_inc      = w_xfer;
        w_data     = w_req_data[r_g*DATA_SIZE +: DATA_SIZE];
        w_grant_id = r_g;
        w_busy     = (r_state == StGrant);
        w_stall    = (r_state == StGrant) & w_holder_valid & w_full;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_p_nxt     = r_p;
        w_rearb     = 1'b0;
`ifdef W_WR_ARB_PKT_LOCK_EN
        w_lock_nxt  = r_lock;
`endif
        unique case (r_state)
            StIdle: begin
                if (|w_req_valid) begin
                    w_state_nxt = StGrant;
                    w_g_nxt     = rr_pick(w_req_valid, r_p);
                end
            end
            StGrant: begin
                if (w_xfer) begin
                    w_p_nxt = r_g;
`ifdef W_WR_ARB_PKT_LOCK_EN
                    w_lock_nxt = ~w_req_last[r_g];
                    w_rearb    = w_req_last[r_g];
`else
                    w_rearb = 1'b1;
`endif
                end else if (!w_holder_valid) begin
                    // Withdrawn valid: move on without advancing the pointer.
`ifdef W_WR_ARB_PKT_LOCK_EN
                    w_rearb = ~r_lock;
`else
                    w_rearb = 1'b1;
`endif
                end
                if (w_rearb) begin
                    if (|w_req_valid) begin
                        w_g_nxt = rr_pick(w_req_valid, r_g);
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= StIdle;
            r_g     <= '0;
            r_p     <= ID_SIZE'(NUM_REQ - 1);
`ifdef W_WR_ARB_PKT_LOCK_EN
            r_lock  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
            r_p     <= w_p_nxt;
`ifdef W_WR_ARB_PKT_LOCK_EN
            r_lock  <= w_lock_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_w_wr_arbiter.sv
// Directed self-checking bench for w_wr_arbiter (NUM_REQ=4, DATA_SIZE=8, ID_SIZE=2).
module tb_w_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned D  = 8;
    localparam int unsigned ID = 2;

    logic           w_clk = 1'b0;
    logic           w_rst;
    logic [N-1:0]   valid, last, ready;
    logic [N*D-1:0] data;
    logic           full_drv, full, inc, busy, stall;
    logic [D-1:0]   wdata;
    logic [ID-1:0]  gid;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic        model_en = 1'b0;
    int unsigned fifo_cnt = 0;
    int          w0;
    int          pulses;
    int          exp_g [5];

    always #5 w_clk = ~w_clk;

    // 16-deep FIFO occupancy model (ADDR_SIZE=4), never drained; full is registered.
    assign full = model_en ? (fifo_cnt == 16) : full_drv;
    always @(posedge w_clk) begin
        if (!model_en) fifo_cnt <= 0;
        else if (inc)  fifo_cnt <= fifo_cnt + 1;
    end

    w_wr_arbiter #(.NUM_REQ(N), .DATA_SIZE(D), .ID_SIZE(ID)) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_req_valid (valid),
        .w_req_data  (data),
        .w_req_last  (last),
        .w_req_ready (ready),
        .w_full      (full),
        .w_inc       (inc),
        .w_data      (wdata),
        .w_grant_id  (gid),
        .w_busy      (busy),
        .w_stall     (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #2;
    endtask

    task automatic do_reset();
        w_rst = 1'b1; valid = '0; last = '0; full_drv = 1'b0;
        tick();
        w_rst = 1'b0;
    endtask

    initial begin
        w_rst = 1'b1; valid = '0; last = '0; data = '0; full_drv = 1'b0;

        // Reset then request
        tick();
        w_rst = 1'b0;
        #1;
        chk("rst_busy",  32'(busy),  0);
        chk("rst_inc",   32'(inc),   0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_gid",   32'(gid),   0);
        valid = 4'b0100; data[2*D +: D] = 8'h5A;
        #1;
        chk("idle_busy",  32'(busy),  0);
        chk("idle_ready", 32'(ready), 0);
        chk("idle_inc",   32'(inc),   0);
        tick(); #1;
        chk("req2_gid",   32'(gid),   2);
        chk("req2_inc",   32'(inc),   1);
        chk("req2_data",  32'(wdata), 32'h5A);
        chk("req2_ready", 32'(ready), 32'b0100);
        valid = '0;
        tick(); #1;
        chk("req2_done_busy", 32'(busy), 0);

        // Rotation, all valid
        do_reset();
        valid = 4'b1111;
        for (int i = 0; i < 4; i++) data[i*D +: D] = 8'(8'h10 + i);
        #1;
        chk("rot_first_inc", 32'(inc), 0);
        for (int k = 0; k < 6; k++) begin
            tick(); #1;
            chk("rot_gid",  32'(gid),   32'(k % 4));
            chk("rot_inc",  32'(inc),   1);
            chk("rot_data", 32'(wdata), 32'(8'h10 + (k % 4)));
        end

        // Full stall
        do_reset();
        valid = 4'b0010; data[1*D +: D] = 8'hA1; data[3*D +: D] = 8'hB3;
        tick();
        full_drv = 1'b1; valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_stall", 32'(stall), 1);
            chk("stall_inc",   32'(inc),   0);
            chk("stall_gid",   32'(gid),   1);
            chk("stall_ready", 32'(ready), 0);
            tick();
        end
        full_drv = 1'b0;
        #1;
        chk("unstall_inc",   32'(inc),   1);
        chk("unstall_gid",   32'(gid),   1);
        chk("unstall_data",  32'(wdata), 32'hA1);
        chk("unstall_ready", 32'(ready), 32'b0010);
        tick();
        valid = 4'b1000;
        #1;
        chk("handover_gid",  32'(gid),   3);
        chk("handover_data", 32'(wdata), 32'hB3);
        chk("handover_inc",  32'(inc),   1);
        valid = '0;
        tick(); #1;
        chk("stall_end_busy", 32'(busy), 0);

        // Packet lock (or per-word interleave without the lock)
`ifdef W_WR_ARB_PKT_LOCK_EN
        exp_g = '{0, 0, 0, 1, 1};
`else
        exp_g = '{0, 1, 0, 1, 0};
`endif
        do_reset();
        data[1*D +: D] = 8'hD0; last[1] = 1'b1; valid[1] = 1'b1;
        w0 = 0; valid[0] = 1'b1; data[7:0] = 8'hC0;
        tick();
        for (int k = 0; k < 5; k++) begin
            valid[0] = (w0 < 3);
            last[0]  = (w0 == 2);
            data[7:0] = 8'(8'hC0 + w0);
            #1;
            chk("pkt_gid",  32'(gid), 32'(exp_g[k]));
            chk("pkt_inc",  32'(inc), 1);
            chk("pkt_data", 32'(wdata), (exp_g[k] == 0) ? 32'(8'hC0 + w0) : 32'hD0);
            tick();
            if (exp_g[k] == 0) w0++;
        end

        // Reset mid-packet
        do_reset();
        valid = 4'b0001; data[7:0] = 8'hE0;
        tick(); #1;
        chk("mid_w1_gid", 32'(gid), 0);
        chk("mid_w1_inc", 32'(inc), 1);
        tick();
        data[7:0] = 8'hE1; w_rst = 1'b1;
        #1;
        chk("mid_rstcyc_inc", 32'(inc), 0);
        tick();
        w_rst = 1'b0; valid = 4'b0110;
        #1;
        chk("mid_after_inc",  32'(inc),  0);
        chk("mid_after_busy", 32'(busy), 0);
        tick(); #1;
        chk("mid_next_gid", 32'(gid), 1);
        chk("mid_next_inc", 32'(inc), 1);

        // Full boundary with a 16-word FIFO
        do_reset();
        model_en = 1'b1; valid = 4'b1111; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (inc) pulses++;
            if (full) chk("inc_while_full", 32'(inc), 0);
            tick();
        end
        chk("fill_pulses", 32'(pulses),   16);
        chk("fill_count",  fifo_cnt,      16);
        chk("fill_full",   32'(full),     1);
        chk("fill_stall",  32'(stall),    1);
        model_en = 1'b0; valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/w_wr_arbiter.md
# w_wr_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO (the write-pointer/full logic and dual-port memory) among `NUM_REQ` requesters in the write clock domain. It drives the FIFO's `w_inc` and write data from one granted requester at a time and gates every transfer with `w_full`. The block is purely write-domain; it performs no clock-domain crossing.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `DATA_SIZE`, default 8: width of one FIFO word.
- `ID_SIZE`, default 2: width of `w_grant_id`; must satisfy 2^`ID_SIZE` >= `NUM_REQ`.

Ports:
- `w_clk`, input, 1: write-domain clock. This is the only clock.
- `w_rst`, input, 1: synchronous, active-high reset, sampled on the rising edge of `w_clk`.
- `w_req_valid`, input, `NUM_REQ`: bit i means requester i presents a word.
- `w_req_data`, input, `NUM_REQ*DATA_SIZE`: requester i data in bits [i*DATA_SIZE +: DATA_SIZE].
- `w_req_last`, input, `NUM_REQ`: bit i marks the final word of requester i's packet.
- `w_req_ready`, output, `NUM_REQ`: bit i means requester i's word is accepted this cycle.
- `w_full`, input, 1: registered full flag from the FIFO write-pointer block.
- `w_inc`, output, 1: write strobe to the FIFO pointer block and memory.
- `w_data`, output, `DATA_SIZE`: data to the FIFO memory.
- `w_grant_id`, output, `ID_SIZE`: index of the current grant holder. Valid only when `w_busy` is 1.
- `w_busy`, output, 1: a grant is held.
- `w_stall`, output, 1: the grant holder is valid but `w_full` is high.

## Operation

- **State register.** Holds state IDLE or GRANT, the grant index g, and the round-robin pointer p (the last-served index).
- **IDLE.**
  - `w_busy`=0 and all ready bits are 0.
  - If any `w_req_valid` bit is set, go to GRANT with g = the first valid index searching p+1, p+2, … modulo `NUM_REQ`.
- **GRANT, transfer condition.** A transfer occurs when `w_req_valid[g]` & ~`w_full`.
- **GRANT, combinational outputs.**
  - `w_req_ready[g]` = ~`w_full`; all other ready bits are 0.
  - `w_inc` = transfer.
  - `w_data` = data slice g.
  - `w_stall` = `w_req_valid[g]` & `w_full`.
- **GRANT, on a transfer.**
  - Set p = g.
  - Re-arbitrate using the same-cycle `w_req_valid`, searching from g+1. Index g is last in the search order.
  - If any request is valid, stay in GRANT with the new g (no bubble). Otherwise go to IDLE.
- **GRANT, no transfer and `w_req_valid[g]`=0.**
  - Requesters must hold valid until ready. If valid is nevertheless withdrawn, the arbiter re-arbitrates as above without updating p.
- **`w_full` high.** No transfer occurs, the grant is held, and `w_stall`=1. Other requesters never win while the holder stalls.
- **Data ordering.** `w_inc` is never asserted while `w_full`=1. FIFO order equals acceptance order.

## Timing

- **Reset values.** State IDLE, p = `NUM_REQ`-1 (requester 0 has highest priority first), `w_grant_id`=0. `w_busy`, `w_inc`, `w_stall` and all `w_req_ready` bits are 0.
- **Reset mid-packet.** The grant is dropped at that edge and any in-progress packet is truncated. Nothing is written in the reset cycle.
- **Latency.**
  - From IDLE, a request is accepted no earlier than the cycle after valid is first seen (1-cycle arbitration).
  - In GRANT, back-to-back transfers run at 1 word per cycle, including handover between requesters.
- **Full handling.** `w_full` is consumed combinationally in the cycle it is high. The pointer block registers full one cycle after the filling write, so the filling write itself is allowed.
- **Fairness.** With all requesters continuously valid and the FIFO never full, grants rotate 0,1,…,`NUM_REQ`-1,0, one word each (or one packet each, see Configuration).
- **Single requester.** A requester that is the only one valid keeps winning with no idle cycles.

## Configuration

- **`W_WR_ARB_PKT_LOCK_EN` defined.**
  - On a transfer with `w_req_last[g]`=0, g is held and no re-arbitration occurs.
  - Re-arbitration happens only on a transfer with `w_req_last[g]`=1.
  - A withdrawn valid does not release the lock.
  - Packets from different requesters are never interleaved in the FIFO.
- **Macro undefined.**
  - `w_req_last` is ignored.
  - Arbitration is per word, as described in Operation.

## Test plan

- **Reset then request.** Reset, then assert `w_req_valid`=4'b0100 with data 0x5A. Required: IDLE for 1 cycle, then `w_grant_id`=2, `w_inc`=1, `w_data`=0x5A, `w_req_ready`=4'b0100.
- **Rotation, all valid.** All four requesters valid continuously, FIFO empty, lock undefined. Required: `w_grant_id` sequence 0,1,2,3,0,1 with `w_inc` high every cycle from the second cycle.
- **Full stall.** Requester 1 granted, then `w_full` held high for 3 cycles while requester 3 is also valid. Required: `w_stall`=1, `w_inc`=0 and `w_grant_id`=1 for all 3 cycles; requester 1's word is written in the first cycle after `w_full` falls.
- **Packet lock.** `W_WR_ARB_PKT_LOCK_EN` defined; requester 0 sends 3 words (last on the third), requester 1 valid throughout. Required: three consecutive writes from requester 0, then requester 1, with no interleave. Same stimulus with the macro undefined yields 0,1,0,1,0.
- **Reset mid-packet.** Assert `w_rst` during word 2 of a locked packet. Required: `w_inc`=0 and `w_busy`=0 after that edge; the next grant goes to the lowest valid index.
- **Full boundary.** Fill the FIFO to capacity through the arbiter with `ADDR_SIZE`=4. Required: exactly 16 `w_inc` pulses before `w_full`, and no `w_inc` while `w_full`=1.
